lim_ramp_seq: RTL and testbench

LIM_RAMP_SEQ -- requirements
Module: lim_ramp_seq

---
 rtl/lim_ramp_seq_if.sv | 23 ++
 rtl/lim_ramp_seq.sv | 196 +++++++++++++++++++
 tb/tb_lim_ramp_seq.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lim_ramp_seq_if.sv
// Local-bus signals around the limit ramp sequencer: the host write request
// coming in, and the arbitrated write going out to the fdbk_core decode.
`timescale 1ns/1ps
interface lim_ramp_seq_if;
  logic        host_write;
  logic [15:0] host_addr;
  logic [31:0] host_data;
  logic        lb_write;
  logic [15:0] lb_addr;
  logic [31:0] lb_data;

  // The sequencer/arbiter: takes host requests, drives the arbitrated bus.
  modport master (
    input  host_write, host_addr, host_data,
    output lb_write, lb_addr, lb_data
  );

  // The host / bus observer side.
  modport slave (
    output host_write, host_addr, host_data,
    input  lb_write, lb_addr, lb_data
  );
endinterface

// File: rtl/lim_ramp_seq.sv
// Limit ramp sequencer: steps the mp_proc lim Y hi/lo dpram pair from a
// start magnitude to a target magnitude, one +cur/-cur write pair per step,
// with a programmable dwell between pairs. Host writes always win the
// local bus; a colliding sequencer write is stalled, never dropped.
`timescale 1ns/1ps
module lim_ramp_seq #(
  parameter logic [15:0] LIM_BASE = 16'd0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic [17:0]    start_lim,
  input  logic [17:0]    target_lim,
  input  logic [17:0]    step_size,
  input  logic [15:0]    dwell,
  lim_ramp_seq_if.master bus,
  output logic           busy,
  output logic           done,
  output logic [17:0]    cur_lim
);

  typedef enum logic [2:0] {IDLE, WR_HI, WR_LO, DWELL, FIN} state_t;

  state_t      state_q, state_d;
  logic [17:0] cur_q, target_q, step_q;
  logic [15:0] dwell_q, cnt_q;
  logic        load_cfg, step_upd, cnt_ld;
  logic        seq_req, seq_go;
  logic [15:0] seq_addr;
  logic [31:0] seq_data;
  logic        wr_en;
  logic [15:0] wr_addr, hold_addr;
  logic [31:0] wr_data, hold_data;

  function automatic logic [17:0] min18(input logic [17:0] a, input logic [17:0] b);
    return (a < b) ? a : b;
  endfunction

  // Next magnitude, saturated at target; 19-bit sum so a large step cannot wrap.
  // A zero step means "go straight to target".
  function automatic logic [17:0] next_lim(input logic [17:0] cur,
                                           input logic [17:0] step,
                                           input logic [17:0] target);
    logic [18:0] sum;
    if (step == 18'd0) return target;
    sum = {1'b0, cur} + {1'b0, step};
    if (sum >= {1'b0, target}) return target;
    return sum[17:0];
  endfunction

  // Negative magnitude, sign-extended to the 32-bit bus word.
  function automatic logic [31:0] neg_ext(input logic [17:0] v);
    logic signed [31:0] s;
    s = $signed({14'd0, v});
    return -s;
  endfunction

  // A sequencer write issues only when the host is not using the bus.
  assign seq_go = seq_req && !bus.host_write;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic, sequencer write request and status outputs.
  always_comb begin
    state_d  = state_q;
    seq_req  = 1'b0;
    seq_addr = LIM_BASE + 16'd1;
    seq_data = 32'd0;
    busy     = 1'b0;
    done     = 1'b0;
    load_cfg = 1'b0;
    step_upd = 1'b0;
    cnt_ld   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          load_cfg = 1'b1;
          state_d  = WR_HI;
        end
      end
      WR_HI: begin
        busy = 1'b1;
        if (abort) begin
          state_d = IDLE;
        end else begin
          seq_req  = 1'b1;
          seq_addr = LIM_BASE + 16'd1;
          seq_data = {14'd0, cur_q};
          if (!bus.host_write) state_d = WR_LO;
        end
      end
      WR_LO: begin
        busy = 1'b1;
        if (abort) begin
          state_d = IDLE;
        end else begin
          seq_req  = 1'b1;
          seq_addr = LIM_BASE + 16'd3;
          seq_data = neg_ext(cur_q);
          if (!bus.host_write) begin
            if (cur_q == target_q) begin
              state_d = FIN;
            end else if (dwell_q == 16'd0) begin
              step_upd = 1'b1;
              state_d  = WR_HI;
            end else begin
              cnt_ld  = 1'b1;
              state_d = DWELL;
            end
          end
        end
      end
      DWELL: begin
        busy = 1'b1;
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q <= 16'd1) begin
          step_upd = 1'b1;
          state_d  = WR_HI;
        end
      end
      FIN: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Ramp configuration, current magnitude, dwell counter and reported limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q    <= 18'd0;
      target_q <= 18'd0;
      step_q   <= 18'd0;
      dwell_q  <= 16'd0;
      cnt_q    <= 16'd0;
      cur_lim  <= 18'd0;
    end else begin
      if (load_cfg) begin
        cur_q    <= min18(start_lim, target_lim);
        target_q <= target_lim;
        step_q   <= step_size;
        dwell_q  <= dwell;
      end else if (step_upd) begin
        cur_q <= next_lim(cur_q, step_q, target_q);
      end
      // Free-running through host writes; only the state decides when to stop.
      if (cnt_ld)
        cnt_q <= dwell_q;
      else if (state_q == DWELL && cnt_q != 16'd0)
        cnt_q <= cnt_q - 16'd1;
      if (state_q == WR_LO && seq_go)
        cur_lim <= cur_q;
    end
  end

  // Bus arbitration: host first, then sequencer, otherwise hold the last word.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = hold_addr;
    wr_data = hold_data;
    if (!rst) begin
      if (bus.host_write) begin
        wr_en   = 1'b1;
        wr_addr = bus.host_addr;
        wr_data = bus.host_data;
      end else if (seq_go) begin
        wr_en   = 1'b1;
        wr_addr = seq_addr;
        wr_data = seq_data;
      end
    end
  end

  // Remember the last word placed on the bus so idle cycles keep it stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_addr <= 16'd0;
      hold_data <= 32'd0;
    end else if (wr_en) begin
      hold_addr <= wr_addr;
      hold_data <= wr_data;
    end
  end

  assign bus.lb_write = wr_en;
  assign bus.lb_addr  = wr_addr;
  assign bus.lb_data  = wr_data;

endmodule

// File: tb/tb_lim_ramp_seq.sv
// Bench for lim_ramp_seq: table of ramp configurations run through a
// write-sequence scoreboard, plus host-collision, abort and reset sequences.
`timescale 1ns/1ps
module tb_lim_ramp_seq;
  localparam logic [15:0] LIM_BASE = 16'd0;
  localparam logic [15:0] HI_ADDR  = LIM_BASE + 16'd1;
  localparam logic [15:0] LO_ADDR  = LIM_BASE + 16'd3;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [17:0] start_lim, target_lim, step_size;
  logic [15:0] dwell;
  logic        busy, done;
  logic [17:0] cur_lim;

  lim_ramp_seq_if bus_if();

  lim_ramp_seq #(.LIM_BASE(LIM_BASE)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .start_lim (start_lim),
    .target_lim(target_lim),
    .step_size (step_size),
    .dwell     (dwell),
    .bus       (bus_if),
    .busy      (busy),
    .done      (done),
    .cur_lim   (cur_lim)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] addr;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [17:0] sl;
    logic [17:0] tl;
    logic [17:0] st;
    logic [15:0] dw;
    int          pairs;
    logic [17:0] fin;
  } vec_t;

  exp_t sb_q[$];
  int n_chk = 0, n_fail = 0;
  int t0 = 0, lo_cnt = 0, done_cnt = 0, done_cyc = 0, host_seen = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] neg32(input int v);
    int n;
    n = -v;
    return n;
  endfunction

  // Expected write pairs for one ramp; shift delays every write (host stall).
  task automatic push_model(input logic [17:0] sl, input logic [17:0] tl, input logic [17:0] st,
                            input logic [15:0] dw, input int shift, input int max_pairs);
    int c, k, t;
    exp_t e;
    t = int'(tl);
    c = (int'(sl) < t) ? int'(sl) : t;
    for (k = 0; k < max_pairs; k++) begin
      e.addr = HI_ADDR; e.data = c;        e.cyc = 1 + shift + k * (int'(dw) + 2);
      sb_q.push_back(e);
      e.addr = LO_ADDR; e.data = neg32(c); e.cyc = e.cyc + 1;
      sb_q.push_back(e);
      if (c == t) break;
      if (st == 18'd0 || c + int'(st) >= t) c = t;
      else c = c + int'(st);
    end
  endtask

  // Bus monitor: host words must pass straight through; sequencer words are
  // matched in order against the scoreboard, including their cycle.
  always @(negedge clk) begin
    exp_t e;
    if (rst === 1'b0) begin
      if (bus_if.host_write) begin
        host_seen++;
        check("host_lb_write", 64'(bus_if.lb_write), 64'd1);
        check("host_lb_addr", 64'(bus_if.lb_addr), 64'(bus_if.host_addr));
        check("host_lb_data", 64'(bus_if.lb_data), 64'(bus_if.host_data));
      end else if (bus_if.lb_write) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h at rel cycle %0d, required no write",
                   bus_if.lb_addr, bus_if.lb_data, cyc - t0);
        end else begin
          e = sb_q.pop_front();
          check("wr_addr", 64'(bus_if.lb_addr), 64'(e.addr));
          check("wr_data", 64'(bus_if.lb_data), 64'(e.data));
          check("wr_cycle", 64'(cyc - t0), 64'(e.cyc));
          if (e.addr == LO_ADDR) lo_cnt++;
        end
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc - t0;
      end
    end
  end

  task automatic start_ramp(input logic [17:0] sl, input logic [17:0] tl,
                            input logic [17:0] st, input logic [15:0] dw);
    @(posedge clk); #1;
    start_lim = sl; target_lim = tl; step_size = st; dwell = dw;
    start = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_rel(input int n);
    while (cyc - t0 < n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run_ramp(input logic [17:0] sl, input logic [17:0] tl, input logic [17:0] st,
                          input logic [15:0] dw, input int exp_pairs, input logic [17:0] exp_fin,
                          input int host_n);
    int lo0, done0, host0, budget, dwi;
    bit seen;
    lo0 = lo_cnt; done0 = done_cnt; host0 = host_seen; dwi = int'(dw);
    push_model(sl, tl, st, dw, host_n, 1000);
    start_ramp(sl, tl, st, dw);
    for (int i = 0; i < host_n; i++) begin
      bus_if.host_write = 1'b1;
      bus_if.host_addr  = 16'h0040 + 16'(i);
      bus_if.host_data  = 32'hA5A5_0000 + 32'(i);
      @(posedge clk); #1;
    end
    bus_if.host_write = 1'b0;
    budget = exp_pairs * (dwi + 2) + host_n + 20;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    check("done_seen", 64'(seen), 64'd1);
    @(negedge clk);
    check("queue_empty", 64'(sb_q.size()), 64'd0);
    check("pairs", 64'(lo_cnt - lo0), 64'(exp_pairs));
    check("done_pulses", 64'(done_cnt - done0), 64'd1);
    check("done_cycle", 64'(done_cyc), 64'(2 + host_n + (exp_pairs - 1) * (dwi + 2) + 1));
    check("done_one_cycle", 64'(done), 64'd0);
    check("busy_after", 64'(busy), 64'd0);
    check("cur_lim", 64'(cur_lim), 64'(exp_fin));
    check("idle_lb_write", 64'(bus_if.lb_write), 64'd0);
    check("hold_addr", 64'(bus_if.lb_addr), 64'(LO_ADDR));
    check("hold_data", 64'(bus_if.lb_data), 64'(neg32(int'(exp_fin))));
    check("host_count", 64'(host_seen - host0), 64'(host_n));
    sb_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tab [8];
    int lo0, done0;
    exp_t e;

    tab[0] = '{18'd1000,    18'd5000,    18'd500,     16'd200, 9, 18'd5000};
    tab[1] = '{18'd4800,    18'd5000,    18'd500,     16'd3,   2, 18'd5000};
    tab[2] = '{18'd1000,    18'd3000,    18'd0,       16'd2,   2, 18'd3000};
    tab[3] = '{18'd6000,    18'd5000,    18'd100,     16'd1,   1, 18'd5000};
    tab[4] = '{18'd0,       18'd0,       18'd10,      16'd0,   1, 18'd0};
    tab[5] = '{18'd7,       18'd9,       18'd1,       16'd0,   3, 18'd9};
    tab[6] = '{18'h3FF00,   18'h3FFFF,   18'h3FFFF,   16'd0,   2, 18'h3FFFF};
    tab[7] = '{18'd5,       18'd5,       18'd7,       16'd4,   1, 18'd5};

    rst = 1'b1; start = 1'b0; abort = 1'b0;
    start_lim = '0; target_lim = '0; step_size = '0; dwell = '0;
    bus_if.host_write = 1'b0; bus_if.host_addr = '0; bus_if.host_data = '0;

    // Reset state before any clock edge.
    #2;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_lb_write", 64'(bus_if.lb_write), 64'd0);
    check("rst_lb_addr", 64'(bus_if.lb_addr), 64'd0);
    check("rst_lb_data", 64'(bus_if.lb_data), 64'd0);
    check("rst_cur_lim", 64'(cur_lim), 64'd0);
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      run_ramp(tab[i].sl, tab[i].tl, tab[i].st, tab[i].dw, tab[i].pairs, tab[i].fin, 0);

    // Host collides with the first WR_HI for three cycles.
    run_ramp(18'd1000, 18'd3000, 18'd1000, 16'd4, 3, 18'd3000, 3);

    // Abort in the dwell after the third pair; a stray start mid-ramp is ignored.
    lo0 = lo_cnt; done0 = done_cnt;
    push_model(18'd1000, 18'd5000, 18'd500, 16'd200, 0, 3);
    start_ramp(18'd1000, 18'd5000, 18'd500, 16'd200);
    wait_rel(100);
    start_lim = 18'd9; target_lim = 18'd9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_rel(450);
    check("busy_pre_abort", 64'(busy), 64'd1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("busy_post_abort", 64'(busy), 64'd0);
    repeat (300) @(posedge clk);
    #1;
    check("abort_queue_empty", 64'(sb_q.size()), 64'd0);
    check("abort_pairs", 64'(lo_cnt - lo0), 64'd3);
    check("abort_no_done", 64'(done_cnt - done0), 64'd0);
    check("abort_cur_lim", 64'(cur_lim), 64'd2000);
    sb_q.delete();

    // Abort and start together in IDLE: the ramp must not begin.
    done0 = done_cnt;
    @(posedge clk); #1;
    start_lim = 18'd100; target_lim = 18'd200; step_size = 18'd50; dwell = 16'd0;
    start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", 64'(busy), 64'd0);
    repeat (10) @(posedge clk);
    #1;
    check("abort_start_no_done", 64'(done_cnt - done0), 64'd0);
    check("abort_start_cur_lim", 64'(cur_lim), 64'd2000);

    // Asynchronous reset in the middle of the first WR_LO.
    e.addr = HI_ADDR; e.data = 32'd1000; e.cyc = 1;
    sb_q.push_back(e);
    start_ramp(18'd1000, 18'd5000, 18'd500, 16'd10);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("arst_lb_write", 64'(bus_if.lb_write), 64'd0);
    check("arst_lb_addr", 64'(bus_if.lb_addr), 64'd0);
    check("arst_lb_data", 64'(bus_if.lb_data), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_cur_lim", 64'(cur_lim), 64'd0);
    @(posedge clk); #3;
    rst = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_busy", 64'(busy), 64'd0);
    check("post_rst_lb_addr", 64'(bus_if.lb_addr), 64'd0);
    check("post_rst_lb_data", 64'(bus_if.lb_data), 64'd0);
    check("post_rst_queue", 64'(sb_q.size()), 64'd0);
    sb_q.delete();
    run_ramp(18'd1000, 18'd2000, 18'd1000, 16'd1, 2, 18'd2000, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
